vga_frame_reader: RTL and testbench

VGA_FRAME_READER -- requirements
Module: vga_frame_reader

---
 rtl/vga_frame_reader.sv | 119 +++++++++++
 tb/tb_vga_frame_reader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// VGA 640x480 scan generator that reads an image window from a 2-clock-latency
// memory port and lines the pixel colour up with the matching sync/blank timing.
module vga_frame_reader #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned IMG_W    = 300,
  parameter int unsigned IMG_H    = 300,
  parameter int unsigned MEM_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [17:0] address_b,
  input  logic [23:0] read_data_b,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned AW      = 18;
  localparam int unsigned DW      = 24;
  localparam int unsigned CW      = 5;
  // Control word layout: {first, vsync_raw, hsync_raw, in_vis, in_img}
  localparam logic [CW-1:0] CTL_RST = 5'b01100;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [AW-1:0] pix_q, pix_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] dly_q [MEM_LAT];
  logic [CW-1:0] ctl, tail;
  logic [DW-1:0] rgb_q;
  logic          hsync_q, vsync_q, blank_q, fs_q;
  logic          h_last, v_last, in_img, in_vis, in_img_nxt;
  logic          hsync_raw, vsync_raw, first;

  // Scan position decode and next-state for counters and image address
  always_comb begin
    h_last     = (h_q == HW'(H_TOTAL - 1));
    v_last     = (v_q == VW'(V_TOTAL - 1));
    in_img     = (h_q < HW'(IMG_W)) && (v_q < VW'(IMG_H));
    in_vis     = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
    hsync_raw  = !((h_q >= HW'(H_ACTIVE + H_FP)) && (h_q < HW'(H_ACTIVE + H_FP + H_SYNC)));
    vsync_raw  = !((v_q >= VW'(V_ACTIVE + V_FP)) && (v_q < VW'(V_ACTIVE + V_FP + V_SYNC)));
    first      = (h_q == '0) && (v_q == '0);
    ctl        = {first, vsync_raw, hsync_raw, in_vis, in_img};
    h_d        = h_last ? '0 : h_q + HW'(1);
    v_d        = v_q;
    if (h_last) begin
      v_d = v_last ? '0 : v_q + VW'(1);
    end
    pix_d = pix_q;
    if (h_last && v_last) begin
      pix_d = '0;
    end else if (in_img) begin
      pix_d = pix_q + AW'(1);
    end
    // Address is registered, so it is computed from the next scan position
    in_img_nxt = (h_d < HW'(IMG_W)) && (v_d < VW'(IMG_H));
    addr_d     = in_img_nxt ? pix_d : '0;
    tail       = dly_q[MEM_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q     <= '0;
      v_q     <= '0;
      pix_q   <= '0;
      addr_q  <= '0;
      for (int unsigned i = 0; i < MEM_LAT; i++) begin
        dly_q[i] <= CTL_RST;
      end
      rgb_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      blank_q <= 1'b0;
      fs_q    <= 1'b0;
    end else if (enable) begin
      h_q      <= h_d;
      v_q      <= v_d;
      pix_q    <= pix_d;
      addr_q   <= addr_d;
      dly_q[0] <= ctl;
      for (int unsigned i = 1; i < MEM_LAT; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
      // Memory data is only meaningful in the stage flagged as in-image
      rgb_q   <= tail[0] ? read_data_b : '0;
      blank_q <= tail[1];
      hsync_q <= tail[2];
      vsync_q <= tail[3];
      fs_q    <= tail[4];
    end
  end

  assign address_b   = addr_q;
  assign red         = rgb_q[23:16];
  assign green       = rgb_q[15:8];
  assign blue        = rgb_q[7:0];
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank_n     = blank_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader on a shrunken screen (24x17 total, 6x5 image)
// with a clock-enabled 2-stage memory returning data = address.
module tb_vga_frame_reader;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 12, VF = 1, VS = 2, VB = 2;
  localparam int IW = 6, IH = 5;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [17:0] address_b;
  logic [23:0] read_data_b = '0;
  logic [17:0] mem_addr_q = '0;
  logic [7:0]  red, green, blue;
  logic        hsync, vsync, blank_n, frame_start;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int last_fs = -1;
  logic adv;

  always #5 clk = ~clk;

  // Memory stage: registered address then registered data, clock-enabled with the scan
  always @(posedge clk) begin
    if (enable) begin
      mem_addr_q  <= address_b;
      read_data_b <= 24'(mem_addr_q);
    end
  end

  vga_frame_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .IMG_W(IW), .IMG_H(IH), .MEM_LAT(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .address_b(address_b), .read_data_b(read_data_b),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .frame_start(frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h (k=%0d)", tag, act, exp, k);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int a);
    int h, v;
    h = a % HT;
    v = (a / HT) % VT;
    return (h < IW && v < IH) ? 32'(v * IW + h) : 32'd0;
  endfunction

  // k = advancing edges since the reset edge; address shows scan k, outputs scan k-3
  task automatic tick();
    logic r, e;
    r = rst;
    e = enable;
    @(posedge clk);
    #1;
    adv = 1'b0;
    if (r) begin
      k = 0;
      last_fs = -1;
    end else if (e) begin
      k++;
      adv = 1'b1;
    end
  endtask

  task automatic check_cycle();
    int s, h, v;
    logic [23:0] px;
    logic eb, eh, ev, ef;
    chk("addr", 32'(address_b), exp_addr(k));
    s = k - 3;
    if (s < 0) begin
      px = '0; eb = 1'b0; eh = 1'b1; ev = 1'b1; ef = 1'b0;
    end else begin
      h  = s % HT;
      v  = (s / HT) % VT;
      eb = (h < HA) && (v < VA);
      eh = !(h >= HA + HF && h < HA + HF + HS);
      ev = !(v >= VA + VF && v < VA + VF + VS);
      ef = (h == 0) && (v == 0);
      px = (h < IW && v < IH) ? 24'(v * IW + h) : 24'd0;
    end
    chk("rgb", 32'({red, green, blue}), 32'(px));
    chk("blank_n", 32'(blank_n), 32'(eb));
    chk("hsync", 32'(hsync), 32'(eh));
    chk("vsync", 32'(vsync), 32'(ev));
    chk("frame_start", 32'(frame_start), 32'(ef));
  endtask

  initial begin
    int lo_h, lo_v, hi_b, n_fs, rise, fall, s;
    lo_h = 0; lo_v = 0; hi_b = 0; n_fs = 0; rise = -1; fall = -1;

    rst = 1'b1;
    enable = 1'b1;
    repeat (3) begin
      tick();
      check_cycle();
    end
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    rst = 1'b0;

    // First frame, with a 5-clock enable drop while in-image pixels are in flight
    for (int n = 0; n < 2 * FR && k < FR + 13; n++) begin
      enable = !(n >= 50 && n < 55);
      tick();
      check_cycle();
      s = k - 3;
      if (adv) begin
        if (k == 1) chk("first_cycle_addr", 32'(address_b), 32'd1);
        if (k == 3) chk("first_fs", 32'(frame_start), 32'd1);
        if (s == 5)   chk("px_w1_0", 32'({red, green, blue}), 32'h000005);
        if (s == 24)  chk("px_0_1", 32'({red, green, blue}), 32'h000006);
        if (s == 101) chk("px_w1_h1", 32'({red, green, blue}), 32'h00001d);
        if (s == 6)   chk("px_w_0", 32'({red, green, blue}), 32'h000000);
        if (frame_start) begin
          if (last_fs >= 0) chk("fs_period", 32'(k - last_fs), 32'(FR));
          last_fs = k;
        end
        if (s >= 0 && s < FR) begin
          lo_h += int'(!hsync);
          lo_v += int'(!vsync);
          hi_b += int'(blank_n);
          n_fs += int'(frame_start);
          if (rise < 0 && blank_n) rise = s;
          if (fall < 0 && !hsync) fall = s;
        end
      end
    end
    chk("run_reached", 32'(k), 32'(FR + 13));
    chk("hsync_low_clks", 32'(lo_h), 32'(VT * HS));
    chk("vsync_low_clks", 32'(lo_v), 32'(VS * HT));
    chk("blank_hi_clks", 32'(hi_b), 32'(HA * VA));
    chk("fs_per_frame", 32'(n_fs), 32'd1);
    chk("hsync_offset", 32'(fall - rise), 32'(HA + HF));

    // Mid-frame reset at scan (4,2), asserted with enable low to show reset priority
    for (int n = 0; n < 2 * FR && k != FR + 2 * HT + 4; n++) begin
      tick();
      check_cycle();
    end
    chk("pre_rst_addr", 32'(address_b), 32'(2 * IW + 4));
    rst = 1'b1;
    enable = 1'b0;
    tick();
    check_cycle();
    chk("mid_rst_addr", 32'(address_b), 32'd0);
    chk("mid_rst_blank", 32'(blank_n), 32'd0);
    chk("mid_rst_hsync", 32'(hsync), 32'd1);
    rst = 1'b0;
    enable = 1'b1;
    for (int n = 0; n < 12; n++) begin
      tick();
      check_cycle();
      if (k == 3) chk("mid_rst_fs", 32'(frame_start), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
